// File: rtl/mem_rw_responder.sv
// Memory-side responder: stores writes, returns read data READ_LAT edges after accept
// through an in-order valid/ready response FIFO; requests stall once RSP_DEPTH reads are outstanding.

module mem_rw_responder_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         head_vld,
    output logic [W-1:0] head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop;

    // A pop only takes effect on a valid head; a push into an empty FIFO is not bypassed.
    assign do_pop   = pop && (count != '0);
    assign head_vld = (count != '0);
    assign head_dat = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld) begin
            slots[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({push_vld, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mem_rw_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [15:0]       err_cnt
);
    localparam int WORDS = 1 << ADDR_W;
    localparam int OW    = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] dat;
    } rsp_t;

    logic [DATA_W-1:0] mem [WORDS];
    logic [WORDS-1:0]  written;
    logic              run_q;
    logic [OW-1:0]     occ;
    logic              acc;
    logic              rd_acc;
    logic              wr_acc;
    logic              pop;
    rsp_t              smp;
    logic              push_vld;
    rsp_t              push_dat;
    logic              head_vld;
    logic [$bits(rsp_t)-1:0] head_raw;
    rsp_t              head;

    // Credit counts reads anywhere between accept and pop, so the FIFO can never overflow.
    assign req_ready = run_q && reset_n && (occ < OW'(RSP_DEPTH));
    assign acc       = req_valid && req_ready;
    assign rd_acc    = acc && !req_write;
    assign wr_acc    = acc && req_write;
    assign pop       = head_vld && rsp_ready;

    assign smp.err = !written[req_addr];
    assign smp.dat = written[req_addr] ? mem[req_addr] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Storage is deliberately left uninitialised; the written flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[req_addr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            written <= '0;
        end else if (wr_acc) begin
            written[req_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ <= '0;
        end else begin
            case ({rd_acc, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    generate
        if (READ_LAT == 1) begin : g_no_stage
            assign push_vld = rd_acc;
            assign push_dat = smp;
        end else begin : g_stage
            localparam int NSTG = READ_LAT - 1;
            logic [NSTG-1:0] stg_vld;
            rsp_t            stg_dat [NSTG];

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    stg_vld <= '0;
                end else begin
                    stg_vld[0] <= rd_acc;
                    for (int i = 1; i < NSTG; i++) begin
                        stg_vld[i] <= stg_vld[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                stg_dat[0] <= smp;
                for (int i = 1; i < NSTG; i++) begin
                    stg_dat[i] <= stg_dat[i-1];
                end
            end

            assign push_vld = stg_vld[NSTG-1];
            assign push_dat = stg_dat[NSTG-1];
        end
    endgenerate

    mem_rw_responder_fifo #(
        .W     ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_raw)
    );

    assign head      = head_raw;
    assign rsp_valid = head_vld;
    assign rsp_data  = head_vld ? head.dat : '0;
    assign rsp_err   = head_vld && head.err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (push_vld && push_dat.err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_rw_responder.sv
// Directed bench for mem_rw_responder at READ_LAT=2, RSP_DEPTH=4.

module tb_mem_rw_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    mem_rw_responder #(
        .ADDR_W(8), .DATA_W(32), .READ_LAT(2), .RSP_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request for one edge; the caller drops req_valid when done.
    task automatic req(input logic w, input logic [7:0] a, input logic [31:0] d);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        tick();
    endtask

    initial begin
        int          acc;
        int          got;
        logic        stall;
        logic [31:0] held;

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        chk("rst_err_cnt",   64'(err_cnt),   64'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        // 1: read of an unwritten address
        rsp_ready = 1'b1;
        req(1'b0, 8'h05, 32'h0);
        req_valid = 1'b0;
        chk("t1_not_yet_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_err",   64'(rsp_err),   64'd1);
        chk("t1_rsp_data",  64'(rsp_data),  64'd0);
        chk("t1_err_cnt",   64'(err_cnt),   64'd1);
        tick();
        chk("t1_drained", 64'(rsp_valid), 64'd0);

        // 2: write then immediate read
        req(1'b1, 8'h10, 32'hDEADBEEF);
        req(1'b0, 8'h10, 32'h0);
        req_valid = 1'b0;
        chk("t2_not_yet_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t2_rsp_data",  64'(rsp_data),  64'hDEADBEEF);
        chk("t2_rsp_err",   64'(rsp_err),   64'd0);
        tick();
        chk("t2_drained", 64'(rsp_valid), 64'd0);

        // 3: overwrite
        req(1'b1, 8'h20, 32'd1);
        req(1'b1, 8'h20, 32'd2);
        req(1'b0, 8'h20, 32'd0);
        req_valid = 1'b0;
        tick();
        chk("t3_rsp_data", 64'(rsp_data), 64'd2);
        chk("t3_rsp_err",  64'(rsp_err),  64'd0);
        chk("t3_err_cnt",  64'(err_cnt),  64'd1);
        tick();

        // 4: credit limit with the consumer stalled
        for (int i = 0; i < 6; i++) req(1'b1, 8'(8'h40 + i), 32'(32'h100 + i));
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        acc = 0;
        req_write = 1'b0; req_addr = 8'h40; req_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (req_ready) acc++;
            tick();
            req_addr = 8'(8'h40 + acc);
        end
        req_valid = 1'b0;
        chk("t4_accepted",    64'(acc),       64'd4);
        chk("t4_req_ready_0", 64'(req_ready), 64'd0);
        chk("t4_head_valid",  64'(rsp_valid), 64'd1);
        chk("t4_rsp0",        64'(rsp_data),  64'h100);
        rsp_ready = 1'b1;
        tick();
        chk("t4_req_ready_1", 64'(req_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            chk("t4_rsp_order", 64'(rsp_data), 64'(32'h100 + i));
            tick();
        end
        chk("t4_drained",  64'(rsp_valid), 64'd0);
        chk("t4_err_cnt",  64'(err_cnt),   64'd1);

        // 5: reset with a queued and an in-flight read
        rsp_ready = 1'b0;
        req(1'b1, 8'h30, 32'hA5);
        req(1'b0, 8'h30, 32'h0);
        req(1'b0, 8'h30, 32'h0);
        req_valid = 1'b0;
        chk("t5_queued_before_rst", 64'(rsp_valid), 64'd1);
        reset_n = 1'b0;
        tick();
        chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
        chk("t5_rst_err_cnt",   64'(err_cnt),   64'd0);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_rsp_after_rst", 64'(rsp_valid), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        req(1'b0, 8'h30, 32'h0);
        req_valid = 1'b0;
        tick();
        chk("t5_reread_valid", 64'(rsp_valid), 64'd1);
        chk("t5_reread_err",   64'(rsp_err),   64'd1);
        chk("t5_reread_data",  64'(rsp_data),  64'd0);
        chk("t5_err_cnt",      64'(err_cnt),   64'd1);
        tick();

        // 6: toggling consumer during continuous reads
        for (int i = 0; i < 8; i++) req(1'b1, 8'(8'h50 + i), 32'(32'hC0DE0000 + i));
        acc = 0; got = 0; stall = 1'b0; held = '0;
        req_write = 1'b0; req_addr = 8'h50; req_valid = 1'b1;
        for (int c = 0; c < 60 && got < 8; c++) begin
            rsp_ready = c[0];
            if (stall) chk("t6_stall_hold", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, held});
            if (rsp_valid && rsp_ready) begin
                chk("t6_rsp_order", 64'(rsp_data), 64'(32'hC0DE0000 + got));
                got++;
            end
            stall = rsp_valid && !rsp_ready;
            held  = rsp_data;
            if (req_valid && req_ready) acc++;
            tick();
            if (acc == 8) req_valid = 1'b0;
            else req_addr = 8'(8'h50 + acc);
        end
        req_valid = 1'b0;
        chk("t6_accepted", 64'(acc), 64'd8);
        chk("t6_received", 64'(got), 64'd8);
        rsp_ready = 1'b1;
        tick();
        chk("t6_no_duplicate", 64'(rsp_valid), 64'd0);
        chk("t6_err_cnt",      64'(err_cnt),   64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
